// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port, redirect input and decoder valid/ready port.
// master = fetch unit (ifetch_queue), slave = surrounding memory/decoder/branch logic.
interface ifetch_queue_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic [DATA_W-1:0] ir_data;
    logic [ADDR_W-1:0] ir_pc;

    modport master (
        output mem_req, mem_addr, ir_valid, ir_data, ir_pc,
        input  mem_ack, mem_rdata, redirect, redirect_pc, ir_ready
    );

    modport slave (
        input  mem_req, mem_addr, ir_valid, ir_data, ir_pc,
        output mem_ack, mem_rdata, redirect, redirect_pc, ir_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, prefetches words into a small FIFO for decode.
// Optional IFETCH_STATS_EN adds saturating fetch/squash counters as extra output ports.
module ifetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    ifetch_queue_if.master     bus_io
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0]        fetch_cnt_o,
    output logic [31:0]        squash_cnt_o
`endif
);

    localparam int unsigned       PtrW    = $clog2(DEPTH);
    localparam int unsigned       CntW    = PtrW + 1;
    localparam logic [CntW-1:0]   DepthC  = CntW'(DEPTH);
    localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDiscard
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pend_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                req_q;

    logic [ADDR_W-1:0]   pc_mem_q   [DEPTH];
    logic [DATA_W-1:0]   data_mem_q [DEPTH];
    logic [PtrW-1:0]     rd_ptr_q;
    logic [PtrW-1:0]     wr_ptr_q;
    logic [CntW-1:0]     count_q;

    logic                redirect;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                ack;
    logic                ir_valid;
    logic                push;
    logic                pop;
    logic [CntW-1:0]     occ_after;
    logic                space_after;

    assign redirect    = bus_io.redirect;
    assign redirect_pc = bus_io.redirect_pc;
    assign ack         = bus_io.mem_ack;
    assign ir_valid    = (count_q != '0);

    // A word is kept only when acked in StWait without a concurrent redirect.
    always_comb begin
        pop         = ir_valid & bus_io.ir_ready;
        push        = (state_q == StWait) & ack & ~redirect;
        occ_after   = count_q + CntW'(push) - CntW'(pop);
        space_after = (occ_after < DepthC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            pend_q  <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (redirect) begin
                        pc_q <= redirect_pc;
                    end else if (count_q < DepthC) begin
                        state_q <= StWait;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                StWait: begin
                    if (redirect) begin
                        if (ack) begin
                            addr_q <= redirect_pc;
                            pc_q   <= redirect_pc;
                        end else begin
                            state_q <= StDiscard;
                            pend_q  <= redirect_pc;
                        end
                    end else if (ack) begin
                        pc_q <= addr_q + AddrOne;
                        if (space_after) begin
                            addr_q <= addr_q + AddrOne;
                        end else begin
                            req_q   <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                StDiscard: begin
                    // Squashed request must still complete; its data is thrown away.
                    if (redirect) begin
                        pend_q <= redirect_pc;
                    end
                    if (ack) begin
                        req_q   <= 1'b0;
                        state_q <= StIdle;
                        pc_q    <= redirect ? redirect_pc : pend_q;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                pc_mem_q[wr_ptr_q]   <= addr_q;
                data_mem_q[wr_ptr_q] <= bus_io.mem_rdata;
                wr_ptr_q             <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= occ_after;
        end
    end

    assign bus_io.mem_req  = req_q;
    assign bus_io.mem_addr = addr_q;
    assign bus_io.ir_valid = ir_valid;
    assign bus_io.ir_data  = data_mem_q[rd_ptr_q];
    assign bus_io.ir_pc    = pc_mem_q[rd_ptr_q];

`ifdef IFETCH_STATS_EN
    logic [31:0]     fetch_cnt_q;
    logic [31:0]     squash_cnt_q;
    logic [CntW-1:0] flushed;
    logic            dropped;
    logic [32:0]     squash_sum;

    // A pop coinciding with a redirect is a completed transfer, not a squash.
    always_comb begin
        flushed    = redirect ? (count_q - CntW'(pop)) : '0;
        dropped    = ack & ((state_q == StDiscard) | ((state_q == StWait) & redirect));
        squash_sum = {1'b0, squash_cnt_q} + 33'(flushed) + 33'(dropped);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            if (push && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            squash_cnt_q <= squash_sum[32] ? '1 : squash_sum[31:0];
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign squash_cnt_o = squash_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: queue-level reference model checked every cycle plus directed scenarios.
// Builds with or without IFETCH_STATS_EN.
module tb_ifetch_queue;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0010;
    localparam logic [31:0] RPC2  = 32'hFFFF_FFFE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    int   lat      = 0;
    logic stray    = 1'b0;
    int   wait_cnt = 0;

    ifetch_queue_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    ifetch_queue_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

`ifdef IFETCH_STATS_EN
    logic [31:0] fetch_cnt, squash_cnt, fetch_cnt2, squash_cnt2;
`endif

    ifetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
`ifdef IFETCH_STATS_EN
        ,
        .fetch_cnt_o  (fetch_cnt),
        .squash_cnt_o (squash_cnt)
`endif
    );

    ifetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(RPC2)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus2)
`ifdef IFETCH_STATS_EN
        ,
        .fetch_cnt_o  (fetch_cnt2),
        .squash_cnt_o (squash_cnt2)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'd1;
    endfunction

    // Memory: acks after `lat` extra cycles of a held request; `stray` forces a spurious ack.
    always_comb begin
        bus.mem_ack    = stray | (bus.mem_req & (wait_cnt >= lat));
        bus.mem_rdata  = mem_word(bus.mem_addr);
        bus2.mem_ack   = bus2.mem_req;
        bus2.mem_rdata = mem_word(bus2.mem_addr);
    end

    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: instruction queue as an SV queue of {pc, word}.
    logic [63:0] mq[$];
    logic        m_init = 1'b0;
    logic        m_req, m_sq;
    logic [31:0] m_addr, m_pc, m_pend;
    logic        s_rst, s_rd, s_ack, s_rdy;
    logic [31:0] s_rpc, s_rdata;
    int          n0;

    always begin
        @(posedge clk);
        s_rst = rst;  s_rd = bus.redirect;  s_rpc = bus.redirect_pc;
        s_ack = bus.mem_ack;  s_rdata = bus.mem_rdata;  s_rdy = bus.ir_ready;
        if (s_rst) begin
            mq.delete();
            m_req = 1'b0;  m_sq = 1'b0;
            m_addr = RPC;  m_pc = RPC;  m_pend = RPC;
            m_init = 1'b1;
        end else if (m_init) begin
            n0 = mq.size();
            if (s_rd) mq.delete();
            else if (n0 > 0 && s_rdy) mq.delete(0);
            if (!m_req) begin
                if (s_rd) m_pc = s_rpc;
                else if (n0 < DEPTH) begin
                    m_req = 1'b1;  m_addr = m_pc;
                end
            end else if (m_sq) begin
                if (s_rd) m_pend = s_rpc;
                if (s_ack) begin
                    m_req = 1'b0;  m_sq = 1'b0;  m_pc = m_pend;
                end
            end else if (s_rd) begin
                if (s_ack) begin
                    m_addr = s_rpc;  m_pc = s_rpc;
                end else begin
                    m_sq = 1'b1;  m_pend = s_rpc;
                end
            end else if (s_ack) begin
                mq.push_back({m_addr, s_rdata});
                m_pc = m_addr + 32'd1;
                if (mq.size() < DEPTH) m_addr = m_addr + 32'd1;
                else m_req = 1'b0;
            end
        end
        if (m_init) begin
            #1;
            chk("mdl_mem_req", bus.mem_req, m_req);
            if (m_req) chk("mdl_mem_addr", bus.mem_addr, m_addr);
            chk("mdl_ir_valid", bus.ir_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("mdl_ir_pc", bus.ir_pc, mq[0][63:32]);
                chk("mdl_ir_data", bus.ir_data, mq[0][31:0]);
            end
        end
    end

    task automatic do_reset(input bit check);
        @(negedge clk);
        rst = 1'b1;
        bus.redirect = 1'b0;
        @(negedge clk);
        if (check) begin
            chk("rst_mem_req", bus.mem_req, 1'b0);
            chk("rst_mem_addr", bus.mem_addr, RPC);
            chk("rst_ir_valid", bus.ir_valid, 1'b0);
            chk("rst_ir_data", bus.ir_data, 32'h0);
            chk("rst_ir_pc", bus.ir_pc, 32'h0);
            chk("rst_mem_addr2", bus2.mem_addr, RPC2);
        end
        rst = 1'b0;
    endtask

    task automatic wait_addr(input logic [31:0] a, input int max, input string name);
        int k = 0;
        while (!(bus.mem_req && bus.mem_addr == a) && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(name, (bus.mem_req && bus.mem_addr == a), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  idx;
        int  k;
        bit  saw;
        bus.redirect = 1'b0;  bus.redirect_pc = '0;  bus.ir_ready = 1'b0;
        bus2.redirect = 1'b0; bus2.redirect_pc = '0; bus2.ir_ready = 1'b1;

        // Zero-wait streaming, decoder always ready.
        lat = 0;  bus.ir_ready = 1'b1;
        do_reset(1);
        @(negedge clk);
        chk("t1_req", bus.mem_req, 1'b1);
        chk("t1_addr10", bus.mem_addr, 32'h10);
        chk("t1_valid0", bus.ir_valid, 1'b0);
        @(negedge clk);
        chk("t1_valid1", bus.ir_valid, 1'b1);
        chk("t1_pc10", bus.ir_pc, 32'h10);
        chk("t1_data10", bus.ir_data, 32'hE377_9B11);
        chk("t1_addr11", bus.mem_addr, 32'h11);
        @(negedge clk);
        chk("t1_pc11", bus.ir_pc, 32'h11);
        chk("t1_addr12", bus.mem_addr, 32'h12);

        // Decoder stalled: queue fills to DEPTH and fetch stops.
        bus.ir_ready = 1'b0;
        do_reset(0);
        repeat (5) @(negedge clk);
        chk("t2_full_req", bus.mem_req, 1'b0);
        chk("t2_full_pc", bus.ir_pc, 32'h10);
        repeat (3) @(negedge clk);
        chk("t2_still_idle", bus.mem_req, 1'b0);
        bus.ir_ready = 1'b1;
        idx = 0;
        for (int j = 0; j < 20 && idx < 8; j++) begin
            if (j == 2) begin
                chk("t2_resume_req", bus.mem_req, 1'b1);
                chk("t2_resume_addr", bus.mem_addr, 32'h14);
            end
            if (bus.ir_valid) begin
                chk("t2_order", bus.ir_pc, 32'h10 + idx);
                idx++;
            end
            @(negedge clk);
        end
        chk("t2_count", idx, 8);

        // Slow memory, redirect while request for 0x12 is pending.
        lat = 3;
        do_reset(0);
        wait_addr(32'h12, 40, "t3_req12");
        @(negedge clk);
        bus.redirect = 1'b1;  bus.redirect_pc = 32'h80;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("t3_hold_req", bus.mem_req, 1'b1);
        chk("t3_hold_addr", bus.mem_addr, 32'h12);
        saw = 1'b0;  k = 0;
        while (!(bus.mem_req && bus.mem_addr == 32'h80) && k < 40) begin
            if (bus.ir_valid && bus.ir_pc == 32'h12) saw = 1'b1;
            @(negedge clk);
            k++;
        end
        chk("t3_next_req80", (bus.mem_req && bus.mem_addr == 32'h80), 1'b1);
        k = 0;
        while (!bus.ir_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("t3_first_pc", bus.ir_pc, 32'h80);
        chk("t3_no_0x12", saw, 1'b0);

        // Redirect coinciding with ack of 0x15 and a head transfer.
        lat = 0;
        do_reset(0);
        wait_addr(32'h15, 20, "t4_req15");
        chk("t4_ack", bus.mem_ack, 1'b1);
        chk("t4_head_valid", bus.ir_valid, 1'b1);
        chk("t4_head_pc", bus.ir_pc, 32'h14);
        bus.redirect = 1'b1;  bus.redirect_pc = 32'h40;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("t4_flushed", bus.ir_valid, 1'b0);
        chk("t4_req40", bus.mem_req, 1'b1);
        chk("t4_addr40", bus.mem_addr, 32'h40);
`ifdef IFETCH_STATS_EN
        chk("t4_fetch_cnt", fetch_cnt, 32'd5);
        chk("t4_squash_cnt", squash_cnt, 32'd1);
`endif
        @(negedge clk);
        chk("t4_valid40", bus.ir_valid, 1'b1);
        chk("t4_pc40", bus.ir_pc, 32'h40);

        // PC wrap on the second instance.
        do_reset(0);
        @(negedge clk);
        chk("t5_addr_fe", bus2.mem_addr, 32'hFFFF_FFFE);
        @(negedge clk);
        chk("t5_addr_ff", bus2.mem_addr, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("t5_addr_00", bus2.mem_addr, 32'h0000_0000);
        chk("t5_pc_ff", bus2.ir_pc, 32'hFFFF_FFFF);

        // Reset while a slow request is outstanding, then a stray ack.
        lat = 3;
        do_reset(0);
        @(negedge clk);
        chk("t6_req_before", bus.mem_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_req_rst", bus.mem_req, 1'b0);
        chk("t6_valid_rst", bus.ir_valid, 1'b0);
`ifdef IFETCH_STATS_EN
        chk("t6_fetch_zero", fetch_cnt, 32'd0);
        chk("t6_squash_zero", squash_cnt, 32'd0);
`endif
        rst = 1'b0;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        chk("t6_restart_req", bus.mem_req, 1'b1);
        chk("t6_restart_addr", bus.mem_addr, RPC);
        chk("t6_no_stray_push", bus.ir_valid, 1'b0);
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch front-end that sits directly upstream of the decode stage.
- Owns the fetch PC and issues word-address requests to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch FIFO and presents them to the decoder with a valid/ready handshake.
- Supports PC redirect (branch/jump) with queue flush and squashing of any in-flight fetch.

Parameters:
- ADDR_W, 32, fetch PC / memory address width (word-addressed, PC increments by 1).
- DATA_W, 32, instruction word width.
- DEPTH, 4, prefetch queue entries (power of two, >= 2).
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  input  1  clock; all logic on posedge clk.
- rst  input  1  reset, synchronous and active-high.
- mem_req  output  1  fetch request, registered.
- mem_addr  output  ADDR_W  fetch word address; stable while mem_req=1 and mem_ack=0.
- mem_ack  input  1  memory returns mem_rdata for the current request this cycle.
- mem_rdata  input  DATA_W  instruction word; valid only with mem_ack.
- redirect  input  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  input  ADDR_W  new fetch address.
- ir_valid  output  1  queue head valid.
- ir_ready  input  1  decoder accepts the head this cycle.
- ir_data  output  DATA_W  head instruction word.
- ir_pc  output  ADDR_W  address of the head instruction.

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC; queue empty; mem_req=0; mem_addr=RESET_PC.
  - ir_valid=0; ir_data=0; ir_pc=0; state=IDLE.
  - Reset mid-request abandons it; a late mem_ack after reset is ignored because mem_req=0.
- States:
  - IDLE: no request outstanding.
  - WAIT: mem_req=1, waiting for ack.
  - DISCARD: request outstanding but squashed; mem_req held with the old address until ack.
- IDLE -> WAIT: when count < DEPTH and no redirect. mem_req rises the next cycle with mem_addr=pc.
- WAIT on mem_ack (no redirect):
  - Push {mem_addr, mem_rdata}; pc = mem_addr+1 (ADDR_W wrap, all-ones -> 0).
  - If post-ack occupancy < DEPTH, stay in WAIT with mem_addr+1 next cycle (back-to-back, 1 word/cycle with zero-wait memory).
  - Otherwise drop mem_req and go to IDLE.
- Occupancy for the space check: count + push - pop, where pop = ir_valid & ir_ready in the same cycle.
- Memory latency: a word acked in cycle N is visible on ir_* in cycle N+1 if the queue was empty.
- Decoder handshake:
  - ir_data/ir_pc hold the head while ir_valid=1.
  - Pop on ir_valid & ir_ready.
  - ir_ready while ir_valid=0 is ignored.
  - Simultaneous push and pop on a full or empty queue are both legal; count is unchanged when full, and the queue stays empty-to-one correctly when empty.
- Redirect (highest priority):
  - Queue flushed next cycle (ir_valid=0); a pop in the same cycle counts as a completed transfer.
  - IDLE: pc=redirect_pc, request next cycle.
  - WAIT with mem_ack the same cycle: acked word dropped, next request uses redirect_pc, stay in WAIT.
  - WAIT without ack: go to DISCARD, latch pending_pc=redirect_pc.
  - DISCARD: a further redirect overwrites pending_pc. On ack, the data is dropped, mem_req=0, and the block goes to IDLE with pc=pending_pc.
- mem_req never drops before mem_ack once raised, except on rst.

Optional Feature:
- Macro: IFETCH_STATS_EN.
- Defined:
  - Adds output ports fetch_cnt[31:0] and squash_cnt[31:0], reset to 0.
  - fetch_cnt increments on every pushed word.
  - squash_cnt increments by the number of valid queue entries flushed plus 1 for each dropped acked word.
  - Both counters saturate at all-ones.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, RESET_PC=0x10, zero-wait memory (mem_ack=mem_req), ir_ready=1 -> mem_addr 0x10,0x11,0x12… on consecutive cycles; ir_pc follows one cycle behind; one instruction per cycle.
- ir_ready=0 with zero-wait memory -> exactly 4 words queued (0x10–0x13), mem_req low. Raise ir_ready -> fetch resumes at 0x14 and ir order is preserved.
- Memory with 3-cycle ack latency, redirect to 0x80 one cycle after the request for 0x12 -> mem_addr stays 0x12 until ack; word 0x12 is never presented; next request is 0x80; first ir_pc after the flush is 0x80.
- Redirect to 0x40 in the same cycle as mem_ack for 0x15 and ir_valid&ir_ready -> the head transfer completes, 0x15 is dropped, the queue is empty next cycle, and the next mem_addr is 0x40.
- pc wrap: RESET_PC=0xFFFFFFFE -> fetches 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Assert rst while in WAIT (ack pending) -> mem_req=0 and ir_valid=0 next cycle; a stray mem_ack is ignored; fetch restarts at RESET_PC. With IFETCH_STATS_EN, both counters read 0.
